// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC, FSM encoding,
// next-PC select codes, the ebreak substitute instruction and AXI response codes.
package ifu_fetch_pkg;

    localparam int unsigned IFU_DATA_WIDTH = 32;
    localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } ifu_state_e;

    // Next-PC mux selection
    typedef enum logic [1:0] {
        PcHold  = 2'd0,
        PcInc   = 2'd1,
        PcRedir = 2'd2,
        PcPend  = 2'd3
    } pc_sel_e;

    // Substituted for the fetched word when memory returns an error response
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ifu_pc_gen.sv
// Next-PC mux for the fetch unit: hold, sequential +4, aligned redirect target or the
// redirect target parked while a dropped transaction drains.
module ifu_pc_gen
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IFU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_pend_pc,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc,
    input  pc_sel_e               i_sel,
    output logic [DATA_WIDTH-1:0] o_pc_next,
    output logic [DATA_WIDTH-1:0] o_pc_plus4,
    output logic [DATA_WIDTH-1:0] o_redirect_tgt
);

    // Low bits of the redirect target are forced to zero
    logic [1:0] w_unused_redirect_lsb;
    assign w_unused_redirect_lsb = i_redirect_pc[1:0];

    assign o_redirect_tgt = {i_redirect_pc[DATA_WIDTH-1:2], 2'b00};
    // Wraps modulo 2^DATA_WIDTH
    assign o_pc_plus4     = i_pc + DATA_WIDTH'(4);

    // Select the PC value for the next cycle
    always_comb begin
        o_pc_next = i_pc;
        unique case (i_sel)
            PcHold:  o_pc_next = i_pc;
            PcInc:   o_pc_next = o_pc_plus4;
            PcRedir: o_pc_next = o_redirect_tgt;
            PcPend:  o_pc_next = i_pend_pc;
            default: o_pc_next = i_pc;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit feeding the IF/ID register. Owns the PC, issues one AXI4-Lite
// style read per instruction and holds the result until IF/ID accepts or EX redirects.
// Optional build macro IFU_PERF_CNT_EN adds fetch and stall performance counters.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC   = DATA_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  Dready,
    output logic                  Ivalid,
    output logic [DATA_WIDTH-1:0] InstF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    ifu_state_e            r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pend_pc;
    logic                  r_drop;
    logic                  r_ivalid;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] r_pcf;
    logic [DATA_WIDTH-1:0] r_pcplus4;

    pc_sel_e               w_pc_sel;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_redirect_tgt;
    logic                  w_accept;

    ifu_pc_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pc_gen (
        .i_pc           (r_pc),
        .i_pend_pc      (r_pend_pc),
        .i_redirect_pc  (redirect_pc),
        .i_sel          (w_pc_sel),
        .o_pc_next      (w_pc_next),
        .o_pc_plus4     (w_pc_plus4),
        .o_redirect_tgt (w_redirect_tgt)
    );

    // A redirect squashes the held instruction in the same cycle
    assign Ivalid   = r_ivalid & ~redirect_valid;
    assign w_accept = Ivalid & Dready;

    assign InstF    = r_inst;
    assign PCF      = r_pcf;
    assign PCPlus4F = r_pcplus4;
    assign araddr   = r_pc;
    assign arvalid  = (r_state == StReq);
    assign rready   = (r_state == StWait);

    // Choose how the PC moves; in REQ it must stay put so araddr is not withdrawn
    always_comb begin
        w_pc_sel = PcHold;
        unique case (r_state)
            StIdle: if (redirect_valid) w_pc_sel = PcRedir;
            StReq:  w_pc_sel = PcHold;
            StWait: begin
                if (rvalid) begin
                    if (redirect_valid) w_pc_sel = PcRedir;
                    else if (r_drop)    w_pc_sel = PcPend;
                end
            end
            StHold: begin
                if (redirect_valid) w_pc_sel = PcRedir;
                else if (w_accept)  w_pc_sel = PcInc;
            end
            default: w_pc_sel = PcHold;
        endcase
    end

    // Fetch FSM: request, wait for data, hold until accepted or redirected
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= StIdle;
            r_pc      <= RESET_PC;
            r_pend_pc <= RESET_PC;
            r_drop    <= 1'b0;
            r_ivalid  <= 1'b0;
            r_inst    <= '0;
            r_pcf     <= '0;
            r_pcplus4 <= '0;
        end else begin
            r_pc <= w_pc_next;
            unique case (r_state)
                StIdle: r_state <= StReq;
                StReq: begin
                    // Redirect before the response: park target, drop the in-flight read
                    if (redirect_valid) begin
                        r_pend_pc <= w_redirect_tgt;
                        r_drop    <= 1'b1;
                    end
                    if (arready) r_state <= StWait;
                end
                StWait: begin
                    if (rvalid) begin
                        if (redirect_valid || r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= StReq;
                        end else begin
                            r_inst    <= (rresp != AXI_RESP_OKAY) ?
                                         DATA_WIDTH'(EBREAK_INST) : rdata;
                            r_pcf     <= r_pc;
                            r_pcplus4 <= w_pc_plus4;
                            r_ivalid  <= 1'b1;
                            r_state   <= StHold;
                        end
                    end else if (redirect_valid) begin
                        r_pend_pc <= w_redirect_tgt;
                        r_drop    <= 1'b1;
                    end
                end
                StHold: begin
                    if (redirect_valid || w_accept) begin
                        r_ivalid <= 1'b0;
                        r_state  <= StReq;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    // Count accepted instructions and cycles stalled by IF/ID; both wrap
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_accept) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            if ((r_state == StHold) && !Dready) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
